// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: access-size encodings, responder states and latency counter width
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int CNT_W = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and response channel (master = requester, slave = responder)
interface data_mem_responder_if;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0] req_size;
  logic req_unsigned;
  logic resp_valid;
  logic resp_ready;
  logic [63:0] resp_rdata;
  logic resp_error;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// dmem_lane_align: store byte enables/lane alignment and load lane extraction with sign/zero extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  lane,
  input  logic [63:0] wdata,
  input  logic [63:0] word,
  input  logic        uns,
  output logic [7:0]  be,
  output logic [63:0] wdata_aligned,
  output logic [63:0] rdata
);
  logic [63:0] sh;
  assign be = size == SZ_B ? 8'h01 << lane :
              size == SZ_H ? 8'h03 << lane :
              size == SZ_W ? 8'h0f << lane : 8'hff;
  assign wdata_aligned = wdata << {lane, 3'b000};
  assign sh = word >> {lane, 3'b000};
  assign rdata = size == SZ_B ? {{56{~uns & sh[7]}}, sh[7:0]} :
                 size == SZ_H ? {{48{~uns & sh[15]}}, sh[15:0]} :
                 size == SZ_W ? {{32{~uns & sh[31]}}, sh[31:0]} : word;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-programmable load/store responder over a local doubleword array.
//   clock, reset (async active-low), bus (slave modport of data_mem_responder_if).
//   With DMEM_PERF_CNT_EN defined: load_count, store_count, error_count saturating counters.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic clock,
  input logic reset,
  data_mem_responder_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [15:0] error_count
`endif
);
  localparam int AW = $clog2(DEPTH * 8);
  state_e state, next;
  logic [CNT_W-1:0] cnt;
  logic wr_q, uns_q, err_q;
  logic [1:0] size_q;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [63:0] mem [DEPTH];
  logic idle, enter_resp, cur_write, cur_uns, err, hs;
  logic [1:0] cur_size;
  logic [63:0] cur_addr, cur_wdata, wdata_al, ld_data;
  logic [7:0] be;
  logic [AW-4:0] idx;
  // In IDLE the live request is used so a zero-latency access can complete on its accepting edge
  assign idle = state == IDLE;
  assign cur_write = idle ? bus.req_write : wr_q;
  assign cur_uns = idle ? bus.req_unsigned : uns_q;
  assign cur_size = idle ? bus.req_size : size_q;
  assign cur_addr = idle ? bus.req_addr : addr_q;
  assign cur_wdata = idle ? bus.req_wdata : wdata_q;
  assign idx = cur_addr[AW-1:3];
  assign err = |cur_addr[63:AW] ||
               (cur_size == SZ_H && cur_addr[0]) ||
               (cur_size == SZ_W && |cur_addr[1:0]) ||
               (cur_size == SZ_D && |cur_addr[2:0]);
  assign enter_resp = next == RESP && state != RESP;
  assign hs = state == RESP && bus.resp_ready;
  assign bus.req_ready = idle;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
  dmem_lane_align u_align (
    .size(cur_size), .lane(cur_addr[2:0]), .wdata(cur_wdata), .word(mem[idx]),
    .uns(cur_uns), .be(be), .wdata_aligned(wdata_al), .rdata(ld_data)
  );
  always_comb begin
    next = state;
    if (idle && bus.req_valid) next = LATENCY == 0 ? RESP : WAIT;
    else if (state == WAIT && cnt == '0) next = RESP;
    else if (hs) next = IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      if (idle && bus.req_valid) begin
        wr_q <= bus.req_write;
        uns_q <= bus.req_unsigned;
        size_q <= bus.req_size;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (enter_resp) begin
        rdata_q <= err || cur_write ? '0 : ld_data;
        err_q <= err;
      end
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (enter_resp && cur_write && !err)
      for (int i = 0; i < 8; i++) if (be[i]) mem[idx][8*i+:8] <= wdata_al[8*i+:8];
`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      load_count <= '0;
      store_count <= '0;
      error_count <= '0;
    end else if (hs) begin
      if (err_q) error_count <= &error_count ? error_count : error_count + 1'b1;
      else if (wr_q) store_count <= &store_count ? store_count : store_count + 1'b1;
      else load_count <= &load_count ? load_count : load_count + 1'b1;
    end
`endif
endmodule
